// File: rtl/pong_pkg.sv
// pong_pkg: shared types, VGA 640x480@60 timing constants, colours and a span hit helper.
package pong_pkg;
  typedef logic [9:0] coord_t;
  localparam int H_VISIBLE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_VISIBLE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [23:0] COLOR_BALL = 24'hFFFFFF;
  localparam logic [23:0] COLOR_PADDLE = 24'h00FF00;
  localparam logic [23:0] COLOR_BG = 24'h000000;
  // 11-bit compare so start + size never wraps back onto low columns/rows
  function automatic logic in_span(input coord_t pos, input coord_t start, input int size);
    return {1'b0, pos} >= {1'b0, start} && {1'b0, pos} < {1'b0, start} + 11'(size);
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel divider, h/v counters, raw sync/visible flags and frame strobes.
// Ports: i_clk, i_rst_n (async active-low); o_tick pixel enable; o_h_cnt/o_v_cnt counters;
// o_hsync_n/o_vsync_n raw active-low syncs; o_visible; o_frame_start at (0,0);
// o_blank_start while the next tick moves to (0, V_VIS).
module vga_timing
  import pong_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int P_H_VIS = H_VISIBLE,
  parameter int P_H_FP = H_FP,
  parameter int P_H_SYNC = H_SYNC,
  parameter int P_H_BP = H_BP,
  parameter int P_V_VIS = V_VISIBLE,
  parameter int P_V_FP = V_FP,
  parameter int P_V_SYNC = V_SYNC,
  parameter int P_V_BP = V_BP
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  output logic   o_tick,
  output coord_t o_h_cnt,
  output coord_t o_v_cnt,
  output logic   o_hsync_n,
  output logic   o_vsync_n,
  output logic   o_visible,
  output logic   o_frame_start,
  output logic   o_blank_start
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam coord_t H_LAST = coord_t'(P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam coord_t V_LAST = coord_t'(P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP - 1);
  localparam coord_t HS_BEG = coord_t'(P_H_VIS + P_H_FP);
  localparam coord_t HS_END = coord_t'(P_H_VIS + P_H_FP + P_H_SYNC);
  localparam coord_t VS_BEG = coord_t'(P_V_VIS + P_V_FP);
  localparam coord_t VS_END = coord_t'(P_V_VIS + P_V_FP + P_V_SYNC);
  logic [DW-1:0] r_div;
  coord_t r_h, r_v;
  logic w_h_last, w_v_last;
  assign o_tick = (CLK_DIV == 1) || (r_div == DW'(CLK_DIV - 1));
  assign w_h_last = r_h == H_LAST;
  assign w_v_last = r_v == V_LAST;
  assign o_h_cnt = r_h;
  assign o_v_cnt = r_v;
  assign o_hsync_n = !(r_h >= HS_BEG && r_h < HS_END);
  assign o_vsync_n = !(r_v >= VS_BEG && r_v < VS_END);
  assign o_visible = r_h < coord_t'(P_H_VIS) && r_v < coord_t'(P_V_VIS);
  assign o_frame_start = r_h == '0 && r_v == '0;
  assign o_blank_start = w_h_last && r_v == coord_t'(P_V_VIS - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_div <= o_tick ? '0 : r_div + 1'b1;
      if (o_tick) begin
        r_h <= w_h_last ? '0 : r_h + 1'b1;
        if (w_h_last) r_v <= w_v_last ? '0 : r_v + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pong_frame_renderer.sv
// pong_frame_renderer: draws ball and paddle on a VGA raster and paces the game with update_screen.
// Ports: i_clk, i_rst_n (async active-low); i_ball_top/i_ball_left/i_paddle_x/i_paddle_y coordinates;
// o_update_screen one-clock pulse at blanking start; o_hsync/o_vsync active-low; o_blank_n;
// o_red/o_green/o_blue pixel colour. All video outputs lag the counters by one pixel tick.
module pong_frame_renderer
  import pong_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W = 8,
  parameter int PADDLE_H = 64,
  parameter int P_H_VIS = H_VISIBLE,
  parameter int P_H_FP = H_FP,
  parameter int P_H_SYNC = H_SYNC,
  parameter int P_H_BP = H_BP,
  parameter int P_V_VIS = V_VISIBLE,
  parameter int P_V_FP = V_FP,
  parameter int P_V_SYNC = V_SYNC,
  parameter int P_V_BP = V_BP
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  coord_t     i_ball_top,
  input  coord_t     i_ball_left,
  input  coord_t     i_paddle_x,
  input  coord_t     i_paddle_y,
  output logic       o_update_screen,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_blank_n,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue
);
  logic w_tick, w_hsync_n, w_vsync_n, w_visible, w_frame_start, w_blank_start, w_ball_hit, w_paddle_hit;
  coord_t w_h_cnt, w_v_cnt, w_ball_top, w_ball_left, w_paddle_x, w_paddle_y;
  coord_t r_ball_top, r_ball_left, r_paddle_x, r_paddle_y;
  logic r_update, r_hsync, r_vsync, r_blank_n;
  logic [23:0] r_rgb;
  vga_timing #(
    .CLK_DIV(CLK_DIV), .P_H_VIS(P_H_VIS), .P_H_FP(P_H_FP), .P_H_SYNC(P_H_SYNC), .P_H_BP(P_H_BP),
    .P_V_VIS(P_V_VIS), .P_V_FP(P_V_FP), .P_V_SYNC(P_V_SYNC), .P_V_BP(P_V_BP)
  ) u_timing (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_tick(w_tick), .o_h_cnt(w_h_cnt), .o_v_cnt(w_v_cnt),
    .o_hsync_n(w_hsync_n), .o_vsync_n(w_vsync_n), .o_visible(w_visible),
    .o_frame_start(w_frame_start), .o_blank_start(w_blank_start)
  );
  // Pixel (0,0) is rendered on the same tick the shadows load, so it sees the values being latched;
  // the whole frame then uses one consistent coordinate set.
  assign w_ball_top = w_frame_start ? i_ball_top : r_ball_top;
  assign w_ball_left = w_frame_start ? i_ball_left : r_ball_left;
  assign w_paddle_x = w_frame_start ? i_paddle_x : r_paddle_x;
  assign w_paddle_y = w_frame_start ? i_paddle_y : r_paddle_y;
  assign w_ball_hit = in_span(w_h_cnt, w_ball_left, BALL_SIZE) && in_span(w_v_cnt, w_ball_top, BALL_SIZE);
  assign w_paddle_hit = in_span(w_h_cnt, w_paddle_x, PADDLE_W) && in_span(w_v_cnt, w_paddle_y, PADDLE_H);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ball_top <= '0;
      r_ball_left <= '0;
      r_paddle_x <= '0;
      r_paddle_y <= '0;
      r_update <= 1'b0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb <= COLOR_BG;
    end else begin
      r_update <= w_tick && w_blank_start;
      if (w_tick) begin
        if (w_frame_start) begin
          r_ball_top <= i_ball_top;
          r_ball_left <= i_ball_left;
          r_paddle_x <= i_paddle_x;
          r_paddle_y <= i_paddle_y;
        end
        r_hsync <= w_hsync_n;
        r_vsync <= w_vsync_n;
        r_blank_n <= w_visible;
        r_rgb <= !w_visible ? COLOR_BG : w_ball_hit ? COLOR_BALL : w_paddle_hit ? COLOR_PADDLE : COLOR_BG;
      end
    end
  end
  assign o_update_screen = r_update;
  assign o_hsync = r_hsync;
  assign o_vsync = r_vsync;
  assign o_blank_n = r_blank_n;
  assign o_red = r_rgb[23:16];
  assign o_green = r_rgb[15:8];
  assign o_blue = r_rgb[7:0];
endmodule

// File: doc/pong_frame_renderer.md
Name: pong_frame_renderer

Overview:
- Downstream consumer of the game-state block. Takes its ball and paddle coordinates and drives a 640x480@60 VGA display.
- Generates the `update_screen` pulse that paces the game-state block: one pulse per frame, at the start of vertical blanking.
- Latches coordinates once per frame so a mid-frame game update never tears the picture.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz clock gives a 25 MHz pixel rate); must be >= 1
- BALL_SIZE, 8, ball edge length in pixels (square)
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- ball_top  in  10  ball top row, from game state
- ball_left  in  10  ball left column, from game state
- paddleX  in  10  paddle left column
- paddleY  in  10  paddle top row
- update_screen  out  1  one-clock pulse per frame; game state advances on it
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank_n  out  1  1 while the pixel is in the visible area
- red  out  8  pixel colour
- green  out  8  pixel colour
- blue  out  8  pixel colour

Behaviour:
- Reset values:
  - pixel divider, h_cnt and v_cnt = 0.
  - hsync = 1, vsync = 1, blank_n = 0, red/green/blue = 0, update_screen = 0.
  - Shadow coordinate registers = 0.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; tick asserts when divider = CLK_DIV-1.
  - All counters and pixel outputs advance only on tick.
  - With CLK_DIV = 1, tick is always high.
- Horizontal counter h_cnt: 0..799, wraps to 0. Line timing:
  - visible 0..639
  - front porch 640..655
  - sync 656..751
  - back porch 752..799
- Vertical counter v_cnt: increments when h_cnt wraps; range 0..524, wraps to 0. Frame timing:
  - visible 0..479
  - front porch 480..489
  - sync 490..491
  - back porch 492..524
- Sync outputs:
  - hsync = 0 exactly for h_cnt in 656..751.
  - vsync = 0 exactly for v_cnt in 490..491.
- Output pipeline:
  - hsync, vsync, blank_n and RGB are registered on tick from the current (h_cnt, v_cnt).
  - Fixed latency of one pixel tick; all five outputs stay mutually aligned.
- Coordinate latching:
  - ball_top, ball_left, paddleX and paddleY are copied into shadow registers on the tick where (h_cnt, v_cnt) = (0, 0).
  - Rendering uses shadow values only; input changes at any other time are invisible until the next frame.
- update_screen:
  - High for exactly one system clock, on the tick where v_cnt becomes 480 and h_cnt becomes 0.
  - Exactly one pulse per 800*525*CLK_DIV clocks.
- Hit tests, all compares 11-bit:
  - Ball hit: col >= ball_left && col < ball_left + BALL_SIZE && row >= ball_top && row < ball_top + BALL_SIZE.
  - Paddle hit: same form using paddleX, PADDLE_W, paddleY and PADDLE_H.
  - Objects partially beyond 639/479 are clipped; they never wrap to column or row 0.
- Colours:
  - ball = FF/FF/FF.
  - paddle = 00/FF/00.
  - background = 00/00/00.
  - Ball has priority over paddle.
  - Outside the visible area, RGB = 0 and blank_n = 0 regardless of hits.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); the frame restarts at (0, 0) after release, and no update_screen pulse fires from the truncated frame.
- Reset release: synchronous deassertion is the integrator's responsibility; the block takes no action on it.

Decomposition:
- Package pong_pkg contains:
  - typedef coord_t as logic [9:0]
  - H_VISIBLE/H_FP/H_SYNC/H_BP (640/16/96/48) and H_TOTAL 800
  - V_VISIBLE/V_FP/V_SYNC/V_BP (480/10/2/33) and V_TOTAL 525
  - colour constants COLOR_BALL, COLOR_PADDLE, COLOR_BG
  - The game-state block shares this package.
- Sub-module vga_timing:
  - Contains the divider, h/v counters, tick, raw sync/visible flags and frame_start/blank_start strobes.
  - The renderer top holds the shadow registers, hit logic and output registers.

Test Plan:
- Reset held low 100 clocks -> hsync = 1, vsync = 1, blank_n = 0, RGB = 0, update_screen = 0. After release, first hsync falling edge at clock 657*2 (+1 tick latency).
- Free-run 2 frames, CLK_DIV = 2 -> hsync low for 192 clocks per line, period 1600 clocks; vsync low for 3200 clocks; update_screen pulses exactly twice, 840000 clocks apart, each 1 clock wide.
- ball_top = 100, ball_left = 200, paddleX = 20, paddleY = 300 -> RGB FFFFFF only at row 100..107 × col 200..207; 00FF00 at row 300..363 × col 20..27; all else 0.
- Overlap, ball_left = 22, ball_top = 310, paddle as above -> pixels row 310..317 × col 22..29 are FFFFFF (ball priority).
- Edge clipping, ball_left = 636, ball_top = 476 -> white only at row 476..479 × col 636..639; column 0..3 of rows 0..3 stays black.
- Change ball_left from 200 to 300 at v_cnt = 240 -> rest of frame still draws at 200; next frame draws at 300. Then drive reset low at v_cnt = 100, release -> no update_screen until v_cnt = 480 of the restarted frame.
